// File: rtl/sinxro_seq_gen.sv
// Tick-driven mux-phase, frame-phase and board-address sequencer running entirely on FRC_IN.
// Define SINXRO_FRAME_CNT_EN to build the 16-bit scan counter on FRAME_CNT (tied to 0 otherwise).
module sinxro_seq_gen #(
    parameter int unsigned DIV    = 6,
    parameter int unsigned N_M    = 4,
    parameter int unsigned N_F    = 6,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned SUBS   = 3,
    parameter int unsigned GROUPS = 6,
    parameter int unsigned WR_ON  = 3,
    parameter int unsigned WR_OFF = 6
) (
    input  logic                                     FRC_IN,
    input  logic                                     RES_HARD,
    input  logic                                     TRIG,
    input  logic                                     COUNTER_F_GO,
    output logic [N_M-1:0]                           M,
    output logic [N_F-1:0]                           F,
    output logic                                     MTR_CLK,
    output logic [$clog2(GROUPS)+$clog2(SUBS)-1:0]   COUNT_BOARD,
    output logic                                     CHENGE_ADRES_IN,
    output logic                                     _RD,
    output logic                                     CLK_BUFER,
    output logic                                     WRITE_BUFER,
    output logic                                     WRITE_TOO_MEM,
    output logic                                     TICK,
    output logic [15:0]                              FRAME_CNT
);
    localparam int unsigned MLEN = 2 * N_M + 1;
    localparam int unsigned FLEN = 2 * N_F;
    localparam int unsigned PW   = $clog2(DIV);
    localparam int unsigned MW   = $clog2(MLEN);
    localparam int unsigned FW   = $clog2(FLEN);
    localparam int unsigned WW   = $clog2(WORDS);
    localparam int unsigned SW   = $clog2(SUBS);
    localparam int unsigned GW   = $clog2(GROUPS);

    logic [PW-1:0]    presc_q, presc_d;
    logic [MW-1:0]    cnt_m_q, cnt_m_d;
    logic             mtr_div_q, mtr_div_d;
    logic             mtr_clk_q, mtr_clk_d;
    logic [N_M-1:0]   m_q, m_d;
    logic [FW-1:0]    cnt_f_q, cnt_f_d;
    logic [N_F-1:0]   f_q, f_d, f_dec;
    logic [WW-1:0]    word_q, word_d;
    logic [SW-1:0]    sub_q, sub_d;
    logic [GW-1:0]    grp_q, grp_d;
    logic [SW+GW-1:0] prev_board_q, prev_board_d;
    logic             wtm_q, wtm_d;
    logic             trig_q, trig_d;
    logic             tick, trig_edge, grp_adv, grp_wrap;

    function automatic logic [N_M-1:0] dec_m(input logic [MW-1:0] c);
        dec_m = '0;
        for (int i = 0; i < int'(N_M); i++) begin
            if (c == MW'(2 * i)) dec_m[i] = 1'b1;
        end
    endfunction

    function automatic logic [N_F-1:0] dec_f(input logic [FW-1:0] c);
        dec_f = '0;
        for (int i = 0; i < int'(N_F); i++) begin
            if (c == FW'(2 * i)) dec_f[i] = 1'b1;
        end
    endfunction

    always_comb begin
        tick      = (presc_q == PW'(DIV - 1));
        trig_edge = TRIG & ~trig_q;
        f_dec     = dec_f(cnt_f_q);
        // Group advances on the falling edge of the last F phase
        grp_adv   = tick & COUNTER_F_GO & ~trig_edge & f_q[N_F-1] & ~f_dec[N_F-1];
        grp_wrap  = grp_adv & (grp_q == GW'(GROUPS - 1));

        presc_d      = tick ? '0 : presc_q + 1'b1;
        cnt_m_d      = cnt_m_q;
        mtr_div_d    = mtr_div_q;
        mtr_clk_d    = mtr_clk_q;
        m_d          = m_q;
        cnt_f_d      = cnt_f_q;
        f_d          = f_q;
        word_d       = word_q;
        sub_d        = sub_q;
        grp_d        = grp_q;
        prev_board_d = prev_board_q;
        wtm_d        = wtm_q;
        trig_d       = trig_q;

        if (tick) begin
            m_d = dec_m(cnt_m_q);
            if (cnt_m_q == MW'(MLEN - 1)) begin
                cnt_m_d   = '0;
                mtr_div_d = ~mtr_div_q;
            end else begin
                cnt_m_d = cnt_m_q + 1'b1;
            end
            // Registered so MTR_CLK reads 0 out of reset, then follows ~mtr_div
            mtr_clk_d    = ~mtr_div_d;
            trig_d       = TRIG;
            prev_board_d = {grp_q, sub_q};

            if (!COUNTER_F_GO) begin
                cnt_f_d = '0;
                f_d     = '0;
                word_d  = '0;
                sub_d   = '0;
                grp_d   = '0;
            end else if (trig_edge) begin
                cnt_f_d = '0;
                f_d     = '0;
                f_d[0]  = 1'b1;
                word_d  = '0;
                sub_d   = '0;
                grp_d   = '0;
            end else begin
                f_d     = f_dec;
                cnt_f_d = (cnt_f_q == FW'(FLEN - 1)) ? '0 : cnt_f_q + 1'b1;
                word_d  = (word_q == WW'(WORDS - 1)) ? '0 : word_q + 1'b1;
                if (word_q == WW'(WORDS - 1)) begin
                    sub_d = (sub_q == SW'(SUBS - 1)) ? '0 : sub_q + 1'b1;
                end
                if (word_q == WW'(WR_ON)) begin
                    wtm_d = 1'b1;
                end else if (word_q == WW'(WR_OFF)) begin
                    wtm_d = 1'b0;
                end
                if (grp_adv) grp_d = grp_wrap ? '0 : grp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge FRC_IN) begin
        if (RES_HARD) begin
            presc_q      <= '0;
            cnt_m_q      <= '0;
            mtr_div_q    <= 1'b0;
            mtr_clk_q    <= 1'b0;
            m_q          <= '0;
            cnt_f_q      <= '0;
            f_q          <= '0;
            word_q       <= '0;
            sub_q        <= '0;
            grp_q        <= '0;
            prev_board_q <= '0;
            wtm_q        <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            cnt_m_q      <= cnt_m_d;
            mtr_div_q    <= mtr_div_d;
            mtr_clk_q    <= mtr_clk_d;
            m_q          <= m_d;
            cnt_f_q      <= cnt_f_d;
            f_q          <= f_d;
            word_q       <= word_d;
            sub_q        <= sub_d;
            grp_q        <= grp_d;
            prev_board_q <= prev_board_d;
            wtm_q        <= wtm_d;
            trig_q       <= trig_d;
        end
    end

`ifdef SINXRO_FRAME_CNT_EN
    logic [15:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (tick && COUNTER_F_GO && trig_edge) begin
            frame_d = '0;
        end else if (grp_wrap) begin
            frame_d = frame_q + 16'd1;
        end
    end

    always_ff @(posedge FRC_IN) begin
        if (RES_HARD) frame_q <= '0;
        else          frame_q <= frame_d;
    end

    assign FRAME_CNT = frame_q;
`else
    assign FRAME_CNT = 16'd0;
`endif

    assign TICK            = tick;
    assign M               = m_q;
    assign F               = f_q;
    assign MTR_CLK         = mtr_clk_q;
    assign COUNT_BOARD     = {grp_q, sub_q};
    assign CHENGE_ADRES_IN = (prev_board_q != {grp_q, sub_q});
    assign _RD             = ~(COUNTER_F_GO & (cnt_f_q[1:0] == 2'd3));
    assign CLK_BUFER       = (cnt_f_q[1:0] == 2'd2);
    assign WRITE_BUFER     = (word_q == WW'(WORDS - 1));
    assign WRITE_TOO_MEM   = wtm_q;

endmodule

// File: doc/sinxro_seq_gen.md
Name: sinxro_seq_gen

Overview:
Parametrised successor of the 4-board sync generator.
- Generates mux phases M, frame phases F, board addressing, read/buffer strobes and the memory write window from one fast clock.
- All sequencing advances on a single internal tick enable, so there are no derived clocks and every flop runs on FRC_IN.
- Sits between the front-end clock input and the board readout/buffer logic.

Parameters:
DIV, 6, FRC_IN cycles per tick (>=2)
N_M, 4, number of M phases; M cycle length 2*N_M+1
N_F, 6, number of F phases; F cycle length 2*N_F (must be a multiple of 4)
WORDS, 8, words per board slot (power of 2)
SUBS, 3, sub-board slots per group
GROUPS, 6, board groups per scan
WR_ON, 3, word index that opens WRITE_TOO_MEM
WR_OFF, 6, word index that closes WRITE_TOO_MEM (WR_ON < WR_OFF < WORDS)

Ports:
FRC_IN  in  1  system clock
RES_HARD  in  1  reset
TRIG  in  1  scan trigger, synchronous to FRC_IN
COUNTER_F_GO  in  1  F/board sequencing enable
M  out  N_M  one-hot mux phases
F  out  N_F  one-hot frame phases
MTR_CLK  out  1  matrix clock, toggles once per M cycle
COUNT_BOARD  out  clog2(GROUPS)+clog2(SUBS)  {grp, sub}
CHENGE_ADRES_IN  out  1  board address changed since last tick
_RD  out  1  read strobe, active low
CLK_BUFER  out  1  buffer clock pulse
WRITE_BUFER  out  1  last word of slot
WRITE_TOO_MEM  out  1  memory write window
TICK  out  1  one-cycle tick pulse
FRAME_CNT  out  16  scan counter (see optional feature)

Interface rule: one clock; reset is synchronous and active-high (FRC_IN, RES_HARD).

Behaviour:
Reset (RES_HARD high at a FRC_IN edge):
- All counters clear.
- M, F, MTR_CLK, COUNT_BOARD, CHENGE_ADRES_IN, CLK_BUFER, WRITE_BUFER, WRITE_TOO_MEM, TICK and FRAME_CNT all = 0.
- _RD = 1.
- Reset mid-sequence aborts immediately; the first tick comes DIV cycles after reset release.

Prescaler:
- Counter mod DIV; TICK = 1 for one cycle when the prescaler = DIV-1.
- All state below changes only on cycles where TICK = 1, except where reset applies.

M sequencer (free running):
- cnt_m mod 2*N_M+1.
- On each tick, M registers onehot(i) if the pre-increment cnt_m == 2*i, else 0.
- On wrap, mtr_div toggles; MTR_CLK = ~mtr_div.

Trigger edge:
- trig_q <= TRIG on each tick; edge = TRIG & ~trig_q, evaluated at the tick.

F sequencer:
- When COUNTER_F_GO = 0 at a tick: cnt_f, word, sub and grp clear; F = 0.
- When COUNTER_F_GO = 1:
  - cnt_f mod 2*N_F; F decodes like M, from the pre-increment value.
  - Edge has priority: cnt_f <= 0, F <= onehot(0), word/sub/grp <= 0, FRAME_CNT <= 0.
- _RD = 0 when COUNTER_F_GO = 1 and cnt_f%4 == 3; otherwise 1.
- CLK_BUFER = (cnt_f%4 == 2). Both are combinational from the registered cnt_f.

Board counters (GO = 1, no edge):
- word increments mod WORDS.
- When word == WORDS-1: sub increments mod SUBS.
- WRITE_TOO_MEM: set at the tick where word == WR_ON; cleared at the tick where word == WR_OFF; otherwise holds.
- WRITE_BUFER = (word == WORDS-1), combinational.
- grp increments mod GROUPS at the tick where F[N_F-1] goes 1->0.
- A simultaneous sub wrap and grp increment are both applied; they are independent fields.

CHENGE_ADRES_IN:
- prev_board <= COUNT_BOARD on each tick.
- Output = (prev_board != COUNT_BOARD).

Optional Feature:
Macro SINXRO_FRAME_CNT_EN.
- Defined: FRAME_CNT increments, wrapping at 16 bits, at each grp wrap GROUPS-1 -> 0; cleared by reset or a trigger edge.
- Undefined: FRAME_CNT is tied to 0 and no counter flops exist.

Test Plan:
1. Reset for 3 cycles, release, defaults -> first TICK at cycle 6. M reads 0001, 0000, 0010, …, 1000, 0000 over 9 ticks. MTR_CLK goes 1 -> 0 after the 9th tick.
2. GO = 1, no trigger -> F onehot at cnt_f 0, 2, …, 10. _RD low at cnt_f 3, 7, 11. CLK_BUFER high at 2, 6, 10.
3. GO = 1 for 8 ticks -> WRITE_TOO_MEM rises at the tick with word 3 and falls at word 6. WRITE_BUFER is high while word = 7. sub increments 0 -> 1. CHENGE_ADRES_IN pulses high for one tick interval.
4. TRIG rises with cnt_f = 7, sub = 2, grp = 4 -> next tick: cnt_f = 0, F = 000001, COUNT_BOARD = 0. Holding TRIG high does not retrigger.
5. GO dropped mid-frame -> at the next tick F = 0, _RD = 1, counters = 0. GO reasserted -> sequencing resumes from F[0].
6. SINXRO_FRAME_CNT_EN defined, 6 full F cycles -> FRAME_CNT = 1. RES_HARD asserted mid-scan -> all outputs at reset values on the next edge.
